// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n beats; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_chunk.sv
// CHUNK-bit ripple slice built from a chain of full-adder bit cells.
module serial_adder_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             ci,
  output logic [CHUNK-1:0] s_c,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_full_adder
    assign s_c[i]   = a_c[i] ^ b_c[i] ^ c[i];
    assign c[i+1]   = (a_c[i] & b_c[i]) | (c[i] & (a_c[i] ^ b_c[i]));
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB first, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int CW    = clog2(BEATS);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("serial_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] s_c;
  logic             co, c_msb_in;
  logic [WIDTH-1:0] acc_next;

  serial_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_c      (a_q[CHUNK-1:0]),
    .b_c      (b_q[CHUNK-1:0]),
    .ci       (carry_q),
    .s_c      (s_c),
    .co       (co),
    .c_msb_in (c_msb_in)
  );

  // New slice bits enter at the top so the LSB slice ends up at the bottom after BEATS shifts.
  if (BEATS == 1) begin : g_single_beat
    assign acc_next = s_c;
  end else begin : g_multi_beat
    assign acc_next = {s_c, acc_q[WIDTH-1:CHUNK]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(BEATS - 1)) begin
          sum_d   = acc_next;
          cout_d  = co;
          ovf_d   = c_msb_in ^ co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
